cells2axis_video: RTL and testbench

- Successor to the single-row cell-to-AXIS converter. Accepts whole rows of Game-of-Life cell states (one bit per cell) from the conware compute core.
- Buffers up to DEPTH rows and expands each cell to an alive/dead colour pixel. Emits PPB pixels per beat on an AXI4-Stream video master.
- Adds video framing: TUSER marks start-of-frame, TLAST marks end-of-line. Sits between the compute core and the VDMA/video-out path.

---
 rtl/conware_pkg.sv | 27 ++
 rtl/conware_row_fifo.sv | 68 ++++++
 rtl/cells2axis_video.sv | 144 ++++++++++++++
 tb/tb_cells2axis_video.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared types and constants for the conware cell-row to AXI4-Stream video path.
// Latency: n/a (package only).
// Backpressure: n/a. Provides the output state encoding, clog2 helper and default beat geometry.
package conware_pkg;

    // Output stage states: nothing presented, or a row being sent beat by beat.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } out_state_e;

    // Ceiling log2, never less than 1 so it is always usable as a vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

    // Default row geometry; modules with other parameters derive their own copies.
    localparam int DEF_WIDTH = 64;
    localparam int DEF_PPB   = 2;
    localparam int BEATS     = DEF_WIDTH / DEF_PPB;
    localparam int BEAT_W    = clog2(BEATS);

endpackage

// File: rtl/conware_row_fifo.sv
// Row FIFO: DEPTH entries of WIDTH-bit cell rows, synchronous push/pop, async active-high reset.
// Latency: a pushed row is visible on rd_data/empty one cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; no pass-through when full.
// Ports: clk, rst, push/wr_data (write side), pop/rd_data (read side, show-ahead), full, empty, count.
module conware_row_fifo
    import conware_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        // DEPTH is a power of two, so the pointers wrap by plain overflow.
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/cells2axis_video.sv
// Cell rows to AXI4-Stream video: buffers rows, expands each cell bit to a colour pixel, PPB pixels per beat.
// Latency: row accepted on E0 into an empty FIFO is popped on E1; TVALID high the cycle after E1.
// Backpressure: in_ready = FIFO not full; output holds TDATA/TLAST/TUSER while TVALID && !TREADY.
// Ports: clk/rst, alive_color/dead_color (latched per frame), in_data/in_valid/in_ready (row input),
//        M_AXIS_* (video master, TUSER = start of frame, TLAST = end of line), frame_done pulse.
module cells2axis_video
    import conware_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 48,
    parameter int PPB    = 2,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DWIDTH-1:0]       alive_color,
    input  logic [DWIDTH-1:0]       dead_color,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DWIDTH*PPB-1:0]   M_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST,
    output logic                    M_AXIS_TUSER,
    output logic                    frame_done
);

    localparam int ROW_BEATS  = WIDTH / PPB;
    localparam int ROW_BEAT_W = clog2(ROW_BEATS);
    localparam int ROW_W      = clog2(HEIGHT);
    localparam int IDX_W      = clog2(WIDTH);
    localparam int CNT_W      = clog2(DEPTH) + 1;

    out_state_e              state_q, state_d;
    logic [ROW_BEAT_W-1:0]   beat_q, beat_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [WIDTH-1:0]        row_data_q, row_data_d;
    logic [DWIDTH-1:0]       alive_q, alive_d;
    logic [DWIDTH-1:0]       dead_q, dead_d;

    logic [WIDTH-1:0]        fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    row_waiting;
    logic                    hs;
    logic                    last_beat;
    logic                    last_row;
    logic [IDX_W-1:0]        col;

    assign in_ready    = ~rst & ~fifo_full;
    assign fifo_push   = in_valid & in_ready;
    assign row_waiting = (fifo_count != '0);
    assign hs          = (state_q == ST_SEND) & M_AXIS_TREADY;
    assign last_beat   = (beat_q == ROW_BEAT_W'(ROW_BEATS - 1));
    assign last_row    = (row_q == ROW_W'(HEIGHT - 1));

    conware_row_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: a last-beat handshake with another row waiting stays in SEND (no bubble).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
            ST_SEND: if (hs && last_beat && fifo_empty) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: pop, beat/row counters and the per-frame colour latch.
    always_comb begin
        fifo_pop   = row_waiting & ((state_q == ST_IDLE) | (hs & last_beat));
        beat_d     = beat_q;
        row_d      = row_q;
        row_data_d = row_data_q;
        alive_d    = alive_q;
        dead_d     = dead_q;
        if (fifo_pop)  beat_d = '0;
        else if (hs)   beat_d = beat_q + ROW_BEAT_W'(1);
        if (hs && last_beat) row_d = last_row ? '0 : row_q + ROW_W'(1);
        if (fifo_pop) begin
            row_data_d = fifo_rd_data;
            // row_d is the index of the row being popped, in both IDLE and turnaround.
            if (row_d == '0) begin
                alive_d = alive_color;
                dead_d  = dead_color;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q     <= '0;
            row_q      <= '0;
            row_data_q <= '0;
            alive_q    <= '0;
            dead_q     <= '0;
        end else begin
            beat_q     <= beat_d;
            row_q      <= row_d;
            row_data_q <= row_data_d;
            alive_q    <= alive_d;
            dead_q     <= dead_d;
        end
    end

    // Outputs. TLAST/TUSER are qualified by TVALID so they read 0 in reset and IDLE.
    always_comb begin
        col           = '0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = (state_q == ST_SEND);
        M_AXIS_TLAST  = M_AXIS_TVALID & last_beat;
        M_AXIS_TUSER  = M_AXIS_TVALID & (row_q == '0) & (beat_q == '0);
        frame_done    = hs & last_beat & last_row;
        for (int k = 0; k < PPB; k++) begin
            col = IDX_W'(int'(beat_q) * PPB + k);
            M_AXIS_TDATA[k*DWIDTH +: DWIDTH] = row_data_q[col] ? alive_q : dead_q;
        end
    end

endmodule

// File: tb/tb_cells2axis_video.sv
module tb_cells2axis_video;

    localparam int DW_A = 32, W_A = 8, H_A = 2, P_A = 2, D_A = 2;
    localparam int DW_B = 16, W_B = 4, H_B = 4, P_B = 1, D_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_a, in_valid_a, in_ready_a, tvalid_a, tready_a, tlast_a, tuser_a, fd_a;
    logic [DW_A-1:0]      alive_a, dead_a;
    logic [W_A-1:0]       in_data_a;
    logic [DW_A*P_A-1:0]  tdata_a;
    logic                 rst_b, in_valid_b, in_ready_b, tvalid_b, tready_b, tlast_b, tuser_b, fd_b;
    logic [DW_B-1:0]      alive_b, dead_b;
    logic [W_B-1:0]       in_data_b;
    logic [DW_B*P_B-1:0]  tdata_b;

    cells2axis_video #(.DWIDTH(DW_A), .WIDTH(W_A), .HEIGHT(H_A), .PPB(P_A), .DEPTH(D_A)) dut_a (
        .clk(clk), .rst(rst_a), .alive_color(alive_a), .dead_color(dead_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .M_AXIS_TDATA(tdata_a), .M_AXIS_TVALID(tvalid_a), .M_AXIS_TREADY(tready_a),
        .M_AXIS_TLAST(tlast_a), .M_AXIS_TUSER(tuser_a), .frame_done(fd_a));

    cells2axis_video #(.DWIDTH(DW_B), .WIDTH(W_B), .HEIGHT(H_B), .PPB(P_B), .DEPTH(D_B)) dut_b (
        .clk(clk), .rst(rst_b), .alive_color(alive_b), .dead_color(dead_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .M_AXIS_TDATA(tdata_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TREADY(tready_b),
        .M_AXIS_TLAST(tlast_b), .M_AXIS_TUSER(tuser_b), .frame_done(fd_b));

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        user;
        logic        fd;
        int          row;
        int          beat;
    } beat_t;

    beat_t q_a[$];
    beat_t q_b[$];
    int    tests = 0, fails = 0;
    int    fd_cnt_a = 0, fd_cnt_b = 0;
    int    row_a = 0, row_b = 0;
    bit    rand_rdy_a = 0, rand_rdy_b = 0;

    // One clock: score handshakes at the falling edge, then step to just after the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (!rst_a && tvalid_a && tready_a) begin
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected_beat got data=%h last=%b user=%b", tdata_a, tlast_a, tuser_a);
            end else begin
                e = q_a.pop_front();
                if ({tdata_a, tlast_a, tuser_a, fd_a} !== {e.data, e.last, e.user, e.fd}) begin
                    fails++;
                    $display("FAIL a_beat row%0d beat%0d got data=%h last=%b user=%b fd=%b want data=%h last=%b user=%b fd=%b",
                             e.row, e.beat, tdata_a, tlast_a, tuser_a, fd_a, e.data, e.last, e.user, e.fd);
                end
            end
            if (fd_a) fd_cnt_a++;
        end else if (fd_a) begin
            tests++; fails++;
            $display("FAIL a_spurious_frame_done got 1 want 0");
        end
        if (!rst_b && tvalid_b && tready_b) begin
            tests++;
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected_beat got data=%h last=%b user=%b", tdata_b, tlast_b, tuser_b);
            end else begin
                e = q_b.pop_front();
                if ({tdata_b, tlast_b, tuser_b, fd_b} !== {e.data[15:0], e.last, e.user, e.fd}) begin
                    fails++;
                    $display("FAIL b_beat row%0d beat%0d got data=%h last=%b user=%b fd=%b want data=%h last=%b user=%b fd=%b",
                             e.row, e.beat, tdata_b, tlast_b, tuser_b, fd_b, e.data[15:0], e.last, e.user, e.fd);
                end
            end
            if (fd_b) fd_cnt_b++;
        end else if (fd_b) begin
            tests++; fails++;
            $display("FAIL b_spurious_frame_done got 1 want 0");
        end
        @(posedge clk);
        #1;
        if (rand_rdy_a) tready_a = 1'($urandom_range(0, 1));
        if (rand_rdy_b) tready_b = 1'($urandom_range(0, 1));
    endtask

    // Offer a row to DUT A and queue its expected beats once it is accepted.
    task automatic push_a(input logic [W_A-1:0] row, input logic [DW_A-1:0] ac, input logic [DW_A-1:0] dc);
        int    n;
        beat_t e;
        in_data_a  = row;
        in_valid_a = 1'b1;
        n = 0;
        while (!in_ready_a && n < 300) begin tick(); n++; end
        if (!in_ready_a) begin
            tests++; fails++;
            $display("FAIL a_push_timeout in_ready=%b want 1", in_ready_a);
        end else begin
            for (int b = 0; b < W_A / P_A; b++) begin
                e.data = '0;
                for (int k = 0; k < P_A; k++)
                    e.data[k*DW_A +: DW_A] = row[b*P_A + k] ? ac : dc;
                e.last = (b == W_A / P_A - 1);
                e.user = (row_a == 0 && b == 0);
                e.fd   = (b == W_A / P_A - 1) && (row_a == H_A - 1);
                e.row  = row_a;
                e.beat = b;
                q_a.push_back(e);
            end
            row_a = (row_a + 1) % H_A;
            tick();
        end
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [W_B-1:0] row, input logic [DW_B-1:0] ac, input logic [DW_B-1:0] dc);
        int    n;
        beat_t e;
        in_data_b  = row;
        in_valid_b = 1'b1;
        n = 0;
        while (!in_ready_b && n < 300) begin tick(); n++; end
        if (!in_ready_b) begin
            tests++; fails++;
            $display("FAIL b_push_timeout in_ready=%b want 1", in_ready_b);
        end else begin
            for (int b = 0; b < W_B; b++) begin
                e.data = '0;
                e.data[DW_B-1:0] = row[b] ? ac : dc;
                e.last = (b == W_B - 1);
                e.user = (row_b == 0 && b == 0);
                e.fd   = (b == W_B - 1) && (row_b == H_B - 1);
                e.row  = row_b;
                e.beat = b;
                q_b.push_back(e);
            end
            row_b = (row_b + 1) % H_B;
            tick();
        end
        in_valid_b = 1'b0;
    endtask

    task automatic drain_a(input int max_cycles);
        int n = 0;
        while (q_a.size() > 0 && n < max_cycles) begin tick(); n++; end
        tests++;
        if (q_a.size() != 0) begin
            fails++;
            $display("FAIL a_drain_timeout beats_left=%0d want 0", q_a.size());
        end
    endtask

    task automatic drain_b(input int max_cycles);
        int n = 0;
        while (q_b.size() > 0 && n < max_cycles) begin tick(); n++; end
        tests++;
        if (q_b.size() != 0) begin
            fails++;
            $display("FAIL b_drain_timeout beats_left=%0d want 0", q_b.size());
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1; in_valid_a = 1'b0;
        tick(); tick();
        q_a.delete(); row_a = 0;
        rst_a = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({tvalid_a, tlast_a, tuser_a, fd_a, in_ready_a, tdata_a} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_a got v=%b l=%b u=%b fd=%b rdy=%b d=%h want all 0",
                     tvalid_a, tlast_a, tuser_a, fd_a, in_ready_a, tdata_a);
        end
        tests++;
        if ({tvalid_b, tlast_b, tuser_b, fd_b, in_ready_b, tdata_b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_b got v=%b l=%b u=%b fd=%b rdy=%b d=%h want all 0",
                     tvalid_b, tlast_b, tuser_b, fd_b, in_ready_b, tdata_b);
        end
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        tests++;
        if ({in_ready_a, tvalid_a, in_ready_b, tvalid_b} !== 4'b1010) begin
            fails++;
            $display("FAIL reset_release got rdy_a=%b v_a=%b rdy_b=%b v_b=%b want 1 0 1 0",
                     in_ready_a, tvalid_a, in_ready_b, tvalid_b);
        end
    endtask

    task automatic test_single_row();
        reset_a();
        tready_a = 1'b1; alive_a = 32'hFFFF_FFFF; dead_a = 32'h0;
        push_a(8'b1010_0110, alive_a, dead_a);
        tests++;
        if (tvalid_a !== 1'b0) begin
            fails++; $display("FAIL single_latency_e0 tvalid=%b want 0", tvalid_a);
        end
        tick();
        tests++;
        if ({tvalid_a, tuser_a, tlast_a, tdata_a} !== {3'b110, 32'hFFFF_FFFF, 32'h0}) begin
            fails++;
            $display("FAIL single_first_beat got v=%b u=%b l=%b d=%h want 1 1 0 ffffffff00000000",
                     tvalid_a, tuser_a, tlast_a, tdata_a);
        end
        drain_a(20);
        tests++;
        if (tvalid_a !== 1'b0) begin
            fails++; $display("FAIL single_idle_after tvalid=%b want 0", tvalid_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW_A*P_A+1:0] snap;
        int fd0;
        reset_a();
        tready_a = 1'b0; alive_a = 32'h00C0_FFEE; dead_a = 32'h0000_0101;
        fd0 = fd_cnt_a;
        push_a(8'hC3, alive_a, dead_a);
        push_a(8'h5A, alive_a, dead_a);
        push_a(8'h0F, alive_a, dead_a);
        tests++;
        if (in_ready_a !== 1'b0) begin
            fails++; $display("FAIL b2b_full in_ready=%b want 0", in_ready_a);
        end
        snap = {tdata_a, tlast_a, tuser_a};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({tdata_a, tlast_a, tuser_a} !== snap || tvalid_a !== 1'b1 || in_ready_a !== 1'b0) begin
                fails++;
                $display("FAIL b2b_stall cycle%0d got d=%h v=%b rdy=%b want d=%h v=1 rdy=0",
                         i, tdata_a, tvalid_a, in_ready_a, snap[DW_A*P_A+1:2]);
            end
        end
        tready_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (tvalid_a !== 1'b1) begin
                fails++; $display("FAIL b2b_bubble beat%0d tvalid=%b want 1", i, tvalid_a);
            end
            tick();
        end
        tests++;
        if (q_a.size() != 0 || tvalid_a !== 1'b0 || fd_cnt_a - fd0 != 1) begin
            fails++;
            $display("FAIL b2b_end left=%0d tvalid=%b frame_done=%0d want 0 0 1", q_a.size(), tvalid_a, fd_cnt_a - fd0);
        end
    endtask

    task automatic test_random_ready();
        int fd0;
        reset_a();
        alive_a = 32'hA5A5_0001; dead_a = 32'h0000_7E7E;
        fd0 = fd_cnt_a;
        rand_rdy_a = 1'b1;
        for (int r = 0; r < 3 * H_A; r++) push_a(8'($urandom), alive_a, dead_a);
        drain_a(500);
        rand_rdy_a = 1'b0; tready_a = 1'b1;
        tests++;
        if (fd_cnt_a - fd0 != 3) begin
            fails++; $display("FAIL random_frame_done got %0d want 3", fd_cnt_a - fd0);
        end
    endtask

    task automatic test_color_change();
        reset_a();
        tready_a = 1'b1; alive_a = 32'h00AA_00AA; dead_a = 32'h0000_0011;
        push_a(8'hF0, 32'h00AA_00AA, 32'h0000_0011);
        push_a(8'h3C, 32'h00AA_00AA, 32'h0000_0011);
        alive_a = 32'h1234_5678;
        push_a(8'h5A, 32'h1234_5678, 32'h0000_0011);
        drain_a(50);
    endtask

    task automatic test_reset_mid_row();
        int n, fd0;
        reset_a();
        tready_a = 1'b1; alive_a = 32'hFFFF_0000; dead_a = 32'h0000_FFFF;
        push_a(8'h81, alive_a, dead_a);
        push_a(8'h7E, alive_a, dead_a);
        push_a(8'h99, alive_a, dead_a);
        n = 0;
        while (!(tvalid_a && q_a.size() > 0 && q_a[0].row == 1 && q_a[0].beat == 2) && n < 50) begin tick(); n++; end
        tests++;
        if (n >= 50) begin
            fails++; $display("FAIL midrst_reach_beat timeout got %0d cycles want <50", n);
        end
        #2 rst_a = 1'b1;
        #1;
        tests++;
        if ({tvalid_a, tlast_a, tuser_a, fd_a, in_ready_a, tdata_a} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs got v=%b l=%b u=%b fd=%b rdy=%b d=%h want all 0",
                     tvalid_a, tlast_a, tuser_a, fd_a, in_ready_a, tdata_a);
        end
        q_a.delete(); row_a = 0;
        fd0 = fd_cnt_a;
        tick(); tick();
        rst_a = 1'b0;
        tick(); tick(); tick();
        tests++;
        if (tvalid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            fails++; $display("FAIL midrst_fifo_empty tvalid=%b rdy=%b want 0 1", tvalid_a, in_ready_a);
        end
        push_a(8'h24, alive_a, dead_a);
        drain_a(20);
        tests++;
        if (fd_cnt_a != fd0) begin
            fails++; $display("FAIL midrst_frame_done got %0d pulses want 0", fd_cnt_a - fd0);
        end
    endtask

    task automatic test_pow2_wrap();
        int fd0;
        rst_b = 1'b1; tick(); tick();
        q_b.delete(); row_b = 0;
        rst_b = 1'b0; tick();
        alive_b = 16'hBEEF; dead_b = 16'h0101;
        fd0 = fd_cnt_b;
        rand_rdy_b = 1'b1;
        for (int r = 0; r < 2 * H_B; r++) push_b(4'($urandom), alive_b, dead_b);
        drain_b(400);
        rand_rdy_b = 1'b0; tready_b = 1'b1;
        tests++;
        if (fd_cnt_b - fd0 != 2) begin
            fails++; $display("FAIL pow2_frame_done got %0d want 2", fd_cnt_b - fd0);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data_a = '0; in_data_b = '0;
        tready_a = 1'b1; tready_b = 1'b1;
        alive_a = 32'hFFFF_FFFF; dead_a = '0;
        alive_b = 16'hBEEF; dead_b = 16'h0101;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_random_ready();
        test_color_change();
        test_reset_mid_row();
        test_pow2_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
